fnd_scan_ctrl: RTL and testbench



---
 rtl/fnd_pkg.sv | 15 +
 rtl/fnd_scan_ctrl_if.sv | 26 ++
 rtl/seg_decoder.sv | 31 +++
 rtl/fnd_scan_ctrl.sv | 114 +++++++++++
 tb/tb_fnd_scan_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fnd_pkg.sv
// Shared constants, types and helpers for the 4-digit FND scan controller.
package fnd_pkg;

  // All segments off (active-low) and all digit commons off (active-low).
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] COM_OFF   = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  // Active-low one-hot common pattern selecting a single digit.
  function automatic logic [3:0] onehot_com(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// Display-side bundle of the FND scan controller: value inputs and drive outputs.
interface fnd_scan_ctrl_if;
  import fnd_pkg::*;

  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp_en;
  logic        lz_blank;
  logic [7:0]  seg;
  logic [3:0]  com;
  digit_idx_t  digit_idx;
  logic        frame_start;

  // Whoever supplies the number to display.
  modport master (
    output enable, value, dp_en, lz_blank,
    input  seg, com, digit_idx, frame_start
  );

  // The scan controller itself.
  modport slave (
    input  enable, value, dp_en, lz_blank,
    output seg, com, digit_idx, frame_start
  );

endinterface

// File: rtl/seg_decoder.sv
// Hex nibble to active-low 7-segment pattern, seg[6:0] = {g,f,e,d,c,b,a}.
module seg_decoder (
  input  logic [3:0] hex_value,
  output logic [6:0] seg
);

  // Pure lookup; shared by all four digits of the scan.
  always_comb begin
    seg = 7'h7F;
    case (hex_value)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode FND.
// One decoder is shared across digits; each slot starts with a dark gap so
// the previous digit's pattern never ghosts onto the next one.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLANK_CYCLES = 100
) (
  input  logic          clk,
  input  logic          reset_p,
  fnd_scan_ctrl_if.slave fnd
);

  localparam int SLOT = CLK_HZ / SCAN_HZ;
  localparam int CW   = (SLOT >= 2) ? $clog2(SLOT) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(SLOT - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  generate
    if (SLOT < 2 || SLOT <= BLANK_CYCLES) begin : g_bad_params
      $error("fnd_scan_ctrl: slot length must be >= 2 and exceed BLANK_CYCLES");
    end
  endgenerate

  logic [CW-1:0] r_tick_cnt;
  digit_idx_t    r_digit_idx;
  logic [15:0]   r_frame_value;
  logic [3:0]    r_frame_dp;
  logic          r_frame_lz;
  logic [3:0]    r_com;
  logic [7:0]    r_seg;
  logic          r_frame_start;

  logic          w_slot_end;
  logic          w_frame_end;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg7;
  logic [3:0]    w_upper_zero;
  logic          w_lz_dark;
  logic          w_dark;

  assign w_slot_end  = (r_tick_cnt == TICK_LAST);
  assign w_frame_end = w_slot_end && (r_digit_idx == 2'd3);

  // w_upper_zero[d]: every latched nibble from digit d up to digit 3 is zero.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_upper_zero
      assign w_upper_zero[gi] = (r_frame_value[15:4*gi] == '0);
    end
  endgenerate

  // Digit 0 is exempt so an all-zero value still shows a single "0".
  assign w_lz_dark = r_frame_lz && (r_digit_idx != 2'd0) && w_upper_zero[r_digit_idx];
  assign w_dark    = !fnd.enable || (r_tick_cnt < BLANK_END) || w_lz_dark;
  assign w_nib     = r_frame_value[4*r_digit_idx +: 4];

  seg_decoder u_seg_decoder (
    .hex_value (w_nib),
    .seg       (w_seg7)
  );

  // Slot timer and digit index; they run regardless of enable.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_tick_cnt  <= '0;
      r_digit_idx <= '0;
    end else if (w_slot_end) begin
      r_tick_cnt  <= '0;
      r_digit_idx <= r_digit_idx + 2'd1;
    end else begin
      r_tick_cnt  <= r_tick_cnt + 1'b1;
    end
  end

  // Snapshot the inputs at the frame wrap so a frame never mixes two values.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_frame_value <= 16'h0000;
      r_frame_dp    <= 4'b0000;
      r_frame_lz    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame_end;
      if (w_frame_end) begin
        r_frame_value <= fnd.value;
        r_frame_dp    <= fnd.dp_en;
        r_frame_lz    <= fnd.lz_blank;
      end
    end
  end

  // Registered pin drive, one clock behind the counter state.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_com <= COM_OFF;
      r_seg <= SEG_BLANK;
    end else if (w_dark) begin
      r_com <= COM_OFF;
      r_seg <= SEG_BLANK;
    end else begin
      r_com <= onehot_com(r_digit_idx);
      r_seg <= {~r_frame_dp[r_digit_idx], w_seg7};
    end
  end

  assign fnd.com         = r_com;
  assign fnd.seg         = r_seg;
  assign fnd.digit_idx   = r_digit_idx;
  assign fnd.frame_start = r_frame_start;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl: per-slot expectations are queued by
// the stimulus process and checked by an independent monitor.
module tb_fnd_scan_ctrl;
  import fnd_pkg::*;

  localparam int CLK_HZ  = 1000;
  localparam int SCAN_HZ = 100;
  localparam int BLANK   = 2;
  localparam int SLOT    = 10;
  localparam int TBL_N   = 9;

  logic clk     = 1'b0;
  logic reset_p = 1'b0;

  fnd_scan_ctrl_if bus ();

  fnd_scan_ctrl #(
    .CLK_HZ       (CLK_HZ),
    .SCAN_HZ      (SCAN_HZ),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .fnd     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         s;
    int         d;
    bit         lit;
    logic [7:0] seg;
    bit [9:0]   en;
  } slot_exp_t;

  slot_exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   phase_slots = 0;
  bit   mon_busy = 1'b0;
  event go;

  // Standard active-low 7-segment glyphs {g,f,e,d,c,b,a} for 0..F.
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Directed frames: value, dp, lz, enable mode (0 off, 1 on, 2 random), change slot/cycle.
  logic [15:0] tbl_val [TBL_N] = '{16'h1234, 16'hABCD, 16'h5678, 16'h0042, 16'h0000,
                                   16'h1002, 16'h9E3C, 16'h9E3C, 16'h0F07};
  logic [3:0]  tbl_dp  [TBL_N] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0100, 4'b0100, 4'b1011};
  logic        tbl_lz  [TBL_N] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  int          tbl_md  [TBL_N] = '{1, 1, 1, 1, 1, 1, 1, 0, 2};
  int          tbl_cs  [TBL_N] = '{0, 2, 1, 0, 3, 1, 0, 0, 2};
  int          tbl_cc  [TBL_N] = '{0, 4, 5, 3, 8, 0, 1, 0, 6};

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // At most one digit common may be low in any cycle.
  always @(negedge clk) begin
    checks++;
    assert ($countones(~bus.com) <= 1)
    else begin
      fails++;
      $display("FAIL com_onehot at %0t: com=%b", $time, bus.com);
    end
  end

  // Monitor: gathers ten output samples per slot and compares them to the queued slot expectation.
  initial begin
    logic [3:0] sc [10];
    logic [7:0] ss [10];
    logic       sf [10];
    logic [1:0] sd [10];
    slot_exp_t  e;
    logic [3:0] ec;
    logic [7:0] es;
    logic       ef;
    logic [1:0] ed;
    int         bad;
    forever begin
      @go;
      mon_busy = 1'b1;
      for (int k = 0; k < phase_slots; k++) begin
        for (int i = 0; i < SLOT; i++) begin
          @(negedge clk);
          sc[i] = bus.com;
          ss[i] = bus.seg;
          sf[i] = bus.frame_start;
          sd[i] = bus.digit_idx;
        end
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL slot_expectation_missing: slot %0d got none required one", k);
        end else begin
          e   = exp_q.pop_front();
          bad = -1;
          for (int i = 0; i < SLOT && bad < 0; i++) begin
            if (i < BLANK || !e.en[i] || !e.lit) begin
              ec = COM_OFF;
              es = SEG_BLANK;
            end else begin
              ec = ~(4'b0001 << e.d);
              es = e.seg;
            end
            ef = (e.d == 3 && i == SLOT - 1);
            ed = (i == SLOT - 1) ? 2'(e.d + 1) : 2'(e.d);
            if (sc[i] !== ec || ss[i] !== es || sf[i] !== ef || sd[i] !== ed) begin
              bad = i;
              fails++;
              $display("FAIL slot_%0d sample %0d: got com=%b seg=%h fs=%b idx=%0d, expected com=%b seg=%h fs=%b idx=%0d",
                       e.s, i, sc[i], ss[i], sf[i], sd[i], ec, es, ef, ed);
            end
          end
          if (bad < 0)
            $display("slot %0d digit %0d lit=%0b en=%b com=%b seg=%h ok",
                     e.s, e.d, e.lit, e.en, sc[SLOT-1], ss[SLOT-1]);
        end
      end
      mon_busy = 1'b0;
    end
  end

  // Reset, release, then drive nframes frames; expectations come from the frame snapshot model.
  task automatic run_phase(input int nframes, input bit use_tbl);
    logic [15:0] sh_val, pd_val, nv;
    logic [3:0]  sh_dp, pd_dp, nd;
    logic        sh_lz, pd_lz, nl;
    int          md, cs, cc, k;
    slot_exp_t   e;

    reset_p      = 1'b1;
    bus.enable   = 1'b1;
    bus.value    = 16'($urandom);
    bus.dp_en    = 4'($urandom);
    bus.lz_blank = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_com", {12'h0, bus.com}, {12'h0, COM_OFF});
    chk("reset_seg", {8'h0, bus.seg}, {8'h0, SEG_BLANK});
    chk("reset_frame_start", {15'h0, bus.frame_start}, 16'h0);
    chk("reset_digit_idx", {14'h0, bus.digit_idx}, 16'h0);

    // Right after reset the display shows the cleared snapshot.
    sh_val = 16'h0; sh_dp = 4'h0; sh_lz = 1'b0;
    pd_val = 16'h0; pd_dp = 4'h0; pd_lz = 1'b0;
    phase_slots = nframes * 4;
    reset_p = 1'b0;
    -> go;

    for (int f = 0; f < nframes; f++) begin
      if (use_tbl && f < TBL_N) begin
        nv = tbl_val[f]; nd = tbl_dp[f]; nl = tbl_lz[f];
        md = tbl_md[f];  cs = tbl_cs[f]; cc = tbl_cc[f];
      end else begin
        k  = int'($urandom_range(0, 4));
        nv = 16'($urandom) >> (4 * k);
        nd = 4'($urandom);
        nl = 1'($urandom_range(0, 1));
        md = 2;
        cs = int'($urandom_range(0, 3));
        cc = int'($urandom_range(0, SLOT - 1));
      end
      if (f > 0) begin
        sh_val = pd_val; sh_dp = pd_dp; sh_lz = pd_lz;
      end
      for (int d = 0; d < 4; d++) begin
        e.s   = 4 * f + d;
        e.d   = d;
        e.lit = !(sh_lz && d != 0 && (sh_val >> (4 * d)) == 16'h0);
        e.seg = {~sh_dp[d], glyph[sh_val[4*d +: 4]]};
        e.en  = '0;
        for (int i = 0; i < SLOT; i++) begin
          if (d == cs && i == cc) begin
            bus.value    = nv;
            bus.dp_en    = nd;
            bus.lz_blank = nl;
          end
          if (md == 2) bus.enable = ($urandom_range(0, 9) != 0);
          else         bus.enable = (md == 1);
          e.en[i] = bus.enable;
          if (d == 3 && i == SLOT - 1) begin
            pd_val = bus.value; pd_dp = bus.dp_en; pd_lz = bus.lz_blank;
          end
          if (i == SLOT - 1) exp_q.push_back(e);
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic wait_mon();
    for (int k = 0; k < 30 && mon_busy; k++) @(negedge clk);
    chk("monitor_done", {15'h0, mon_busy}, 16'h0);
  endtask

  initial begin
    bus.enable   = 1'b0;
    bus.value    = 16'h0;
    bus.dp_en    = 4'h0;
    bus.lz_blank = 1'b0;
    #1;

    run_phase(26, 1'b1);
    wait_mon();

    // Asynchronous reset while a digit is lit must darken the outputs before the next edge.
    bus.enable = 1'b1;
    for (int k = 0; k < 30 && bus.com == COM_OFF; k++) @(negedge clk);
    chk("lit_before_reset", {15'h0, (bus.com != COM_OFF)}, 16'h1);
    #1;
    reset_p = 1'b1;
    #1;
    chk("async_reset_com", {12'h0, bus.com}, {12'h0, COM_OFF});
    chk("async_reset_seg", {8'h0, bus.seg}, {8'h0, SEG_BLANK});
    chk("async_reset_fs", {15'h0, bus.frame_start}, 16'h0);
    chk("async_reset_idx", {14'h0, bus.digit_idx}, 16'h0);

    run_phase(3, 1'b0);
    wait_mon();
    chk("queue_drained", 16'(exp_q.size()), 16'h0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: run time exceeded, checks=%0d fails=%0d", checks, fails);
    $fatal(1, "watchdog");
  end

endmodule
